// File: rtl/sm_pkg.sv
// Shared sign-magnitude definitions: the 8-bit sample type, its sign bit position
// and the FSM state encoding used by the block-statistics blocks.
package sm_pkg;

    typedef logic [7:0] sm_t;

    localparam int SM_SIGN_BIT = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/sm_gt.sv
// Combinational numeric greater-than for sign-magnitude values (a > b).
// +0 and -0 compare equal.
module sm_gt
    import sm_pkg::*;
(
    input  sm_t  a,
    input  sm_t  b,
    output logic gt
);

    logic                   a_neg;
    logic                   b_neg;
    logic [SM_SIGN_BIT-1:0] a_mag;
    logic [SM_SIGN_BIT-1:0] b_mag;
    logic                   both_zero;

    assign a_neg     = a[SM_SIGN_BIT];
    assign b_neg     = b[SM_SIGN_BIT];
    assign a_mag     = a[SM_SIGN_BIT-1:0];
    assign b_mag     = b[SM_SIGN_BIT-1:0];
    assign both_zero = (a_mag == '0) && (b_mag == '0);

    // Once the two zero encodings are excluded, any non-negative a beats any negative b.
    always_comb begin
        gt = 1'b0;
        if (!both_zero) begin
            case ({a_neg, b_neg})
                2'b00:   gt = (a_mag > b_mag);
                2'b01:   gt = 1'b1;
                2'b10:   gt = 1'b0;
                default: gt = (a_mag < b_mag);
            endcase
        end
    end

endmodule

// File: rtl/sm_block_max.sv
// Block maximum (and optional minimum, enabled by macro SM_BLOCK_MIN_EN) of BLOCK_LEN
// sign-magnitude samples, with valid/ready handshakes on both input and result.
module sm_block_max
    import sm_pkg::*;
#(
    parameter int BLOCK_LEN = 8,
    parameter int IDX_W     = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  sm_t              in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output sm_t              max_data,
    output logic [IDX_W-1:0] max_idx,
    output logic             busy
`ifdef SM_BLOCK_MIN_EN
    ,
    output sm_t              min_data,
    output logic [IDX_W-1:0] min_idx
`endif
);

    state_t           state;
    logic [IDX_W-1:0] cnt;
    logic             accept;
    logic             last;
    logic             first;
    logic             max_gt;

    assign accept = in_valid && in_ready;
    assign last   = (cnt == IDX_W'(BLOCK_LEN - 1));
    assign first  = (cnt == '0);

    sm_gt u_max_gt (
        .a  (in_data),
        .b  (max_data),
        .gt (max_gt)
    );

`ifdef SM_BLOCK_MIN_EN
    logic min_lt;

    // Stored minimum greater than the sample means the sample is strictly smaller.
    sm_gt u_min_gt (
        .a  (min_data),
        .b  (in_data),
        .gt (min_lt)
    );
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            max_data  <= '0;
            max_idx   <= '0;
`ifdef SM_BLOCK_MIN_EN
            min_data  <= '0;
            min_idx   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= ACCUM;
                        cnt      <= '0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        if (first || max_gt) begin
                            max_data <= in_data;
                            max_idx  <= cnt;
                        end
`ifdef SM_BLOCK_MIN_EN
                        if (first || min_lt) begin
                            min_data <= in_data;
                            min_idx  <= cnt;
                        end
`endif
                        // The counter parks on the last index; it is cleared on return to IDLE.
                        if (last) begin
                            state     <= DONE;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end else begin
                            cnt <= cnt + IDX_W'(1);
                        end
                    end
                end
                DONE: begin
                    if (out_valid && out_ready) begin
                        state     <= IDLE;
                        cnt       <= '0;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cnt       <= '0;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
